// File: rtl/recovery_rx_framer.sv
// recovery_rx_framer: parses I3C recovery write frames (cmd, 16-bit LE length, payload, PEC) and streams the payload.
// Define RECOVERY_RX_PEC_CHECK_EN to drive the external CRC-8 engine and check the received PEC byte.
module recovery_rx_framer #(
  parameter int MaxLen = 256
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        frame_start_i,
  input  logic        frame_stop_i,
  input  logic [6:0]  addr_i,
  input  logic        rx_valid_i,
  output logic        rx_ready_o,
  input  logic [7:0]  rx_data_i,
  output logic        data_valid_o,
  input  logic        data_ready_i,
  output logic [7:0]  data_o,
  output logic        hdr_valid_o,
  output logic [7:0]  cmd_o,
  output logic [15:0] len_o,
  output logic        done_o,
  output logic        pec_err_o,
  output logic        len_err_o,
  output logic        pec_valid_o,
  output logic        pec_init_o,
  output logic [7:0]  pec_dat_o,
  input  logic [8-1:0] pec_crc_i,
  output logic [3:0]  state_o
);

  // Handshake: a byte moves on any cycle where valid and ready are both high; the
  // source holds data stable while valid is high and ready is low. Payload bytes
  // pass straight through, so upstream ready follows downstream ready in DATA.

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_ADDR      = 4'd1,
    S_CMD       = 4'd2,
    S_LEN_L     = 4'd3,
    S_LEN_H     = 4'd4,
    S_DATA      = 4'd5,
    S_PEC       = 4'd6,
    S_WAIT_STOP = 4'd7,
    S_DRAIN     = 4'd8
  } state_e;

  localparam logic [16:0] MaxLenW = 17'(MaxLen);

  state_e      state_q, state_d;
  logic [7:0]  cmd_q;
  logic [15:0] len_q;
  logic [15:0] rem_q;
  logic        hdr_q;
  logic        done_q;
  logic        len_err_q;

  logic        rx_ready;
  logic        acc;
  logic        in_frame;
  logic        short_state;
  logic        stop_hit;
  logic        len_over;
  logic [15:0] len_full;

  assign len_full = {rx_data_i, len_q[7:0]};
  assign len_over = {1'b0, len_full} > MaxLenW;

  always_comb begin
    in_frame    = 1'b0;
    short_state = 1'b0;
    rx_ready    = 1'b0;
    case (state_q)
      S_CMD, S_LEN_L, S_LEN_H, S_PEC: begin
        in_frame    = 1'b1;
        short_state = 1'b1;
        rx_ready    = 1'b1;
      end
      S_DATA: begin
        in_frame    = 1'b1;
        short_state = 1'b1;
        rx_ready    = data_ready_i;
      end
      S_WAIT_STOP, S_DRAIN: begin
        in_frame = 1'b1;
        rx_ready = 1'b1;
      end
      default: ;
    endcase
    if (frame_stop_i) rx_ready = 1'b0;
  end

  assign acc      = rx_valid_i && rx_ready;
  // A simultaneous start overrides the stop, so the old frame never reports done.
  assign stop_hit = frame_stop_i && in_frame && !frame_start_i;

  always_comb begin
    state_d = state_q;
    if (frame_start_i) begin
      state_d = S_ADDR;
    end else if (stop_hit) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_ADDR:  state_d = S_CMD;
        S_CMD:   if (acc) state_d = S_LEN_L;
        S_LEN_L: if (acc) state_d = S_LEN_H;
        S_LEN_H: begin
          if (acc) begin
            if (len_over)               state_d = S_DRAIN;
            else if (len_full == 16'd0) state_d = S_PEC;
            else                        state_d = S_DATA;
          end
        end
        S_DATA:  if (acc && rem_q == 16'd1) state_d = S_PEC;
        S_PEC:   if (acc) state_d = S_WAIT_STOP;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      cmd_q     <= 8'h00;
      len_q     <= 16'h0000;
      rem_q     <= 16'h0000;
      hdr_q     <= 1'b0;
      done_q    <= 1'b0;
      len_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      hdr_q   <= 1'b0;
      done_q  <= stop_hit;
      if (frame_start_i) begin
        cmd_q     <= 8'h00;
        len_q     <= 16'h0000;
        len_err_q <= 1'b0;
      end else begin
        if (stop_hit && short_state) len_err_q <= 1'b1;
        if (acc) begin
          case (state_q)
            S_CMD:   cmd_q <= rx_data_i;
            S_LEN_L: len_q[7:0] <= rx_data_i;
            S_LEN_H: begin
              len_q[15:8] <= rx_data_i;
              rem_q       <= len_full;
              hdr_q       <= 1'b1;
              if (len_over) len_err_q <= 1'b1;
            end
            S_DATA:      rem_q <= rem_q - 16'd1;
            S_WAIT_STOP: len_err_q <= 1'b1;
            default: ;
          endcase
        end
      end
    end
  end

  assign data_valid_o = (state_q == S_DATA) && rx_valid_i && !frame_stop_i;
  assign data_o       = (state_q == S_DATA) ? rx_data_i : 8'h00;
  assign rx_ready_o   = rx_ready;
  assign hdr_valid_o  = hdr_q;
  assign cmd_o        = cmd_q;
  assign len_o        = len_q;
  assign done_o       = done_q;
  assign len_err_o    = len_err_q;
  assign state_o      = state_q;

`ifdef RECOVERY_RX_PEC_CHECK_EN
  logic [6:0] addr_q;
  logic       pec_err_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      addr_q    <= 7'h00;
      pec_err_q <= 1'b0;
    end else if (frame_start_i) begin
      addr_q    <= addr_i;
      pec_err_q <= 1'b0;
    end else if (acc && state_q == S_PEC) begin
      pec_err_q <= (rx_data_i != pec_crc_i);
    end
  end

  // The CRC engine seeds itself with the write address byte, then absorbs header and payload.
  always_comb begin
    pec_valid_o = 1'b0;
    pec_init_o  = 1'b0;
    pec_dat_o   = 8'h00;
    case (state_q)
      S_ADDR: begin
        pec_valid_o = 1'b1;
        pec_init_o  = 1'b1;
        pec_dat_o   = {addr_q, 1'b0};
      end
      S_CMD, S_LEN_L, S_LEN_H, S_DATA: begin
        if (acc) begin
          pec_valid_o = 1'b1;
          pec_dat_o   = rx_data_i;
        end
      end
      default: ;
    endcase
  end

  assign pec_err_o = pec_err_q;
`else
  logic unused_pec_inputs;
  assign unused_pec_inputs = ^{pec_crc_i, addr_i};

  assign pec_valid_o = 1'b0;
  assign pec_init_o  = 1'b0;
  assign pec_dat_o   = 8'h00;
  assign pec_err_o   = 1'b0;
`endif

endmodule

// File: tb/tb_recovery_rx_framer.sv
// Bench for recovery_rx_framer: vector table, hand-written corner sequences and random frames
// against a frame-level model; includes a behavioural CRC-8 engine standing in for recovery_pec.
module tb_recovery_rx_framer;

  localparam int MaxLen = 256;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        frame_start_i = 1'b0;
  logic        frame_stop_i = 1'b0;
  logic [6:0]  addr_i = 7'h00;
  logic        rx_valid_i = 1'b0;
  logic        rx_ready_o;
  logic [7:0]  rx_data_i = 8'h00;
  logic        data_valid_o;
  logic        data_ready_i = 1'b0;
  logic [7:0]  data_o;
  logic        hdr_valid_o;
  logic [7:0]  cmd_o;
  logic [15:0] len_o;
  logic        done_o;
  logic        pec_err_o;
  logic        len_err_o;
  logic        pec_valid_o;
  logic        pec_init_o;
  logic [7:0]  pec_dat_o;
  logic [7:0]  pec_crc_i;
  logic [3:0]  state_o;

  recovery_rx_framer #(.MaxLen(MaxLen)) dut (
    .clk_i(clk), .rst_i(rst_i), .frame_start_i(frame_start_i), .frame_stop_i(frame_stop_i),
    .addr_i(addr_i), .rx_valid_i(rx_valid_i), .rx_ready_o(rx_ready_o), .rx_data_i(rx_data_i),
    .data_valid_o(data_valid_o), .data_ready_i(data_ready_i), .data_o(data_o),
    .hdr_valid_o(hdr_valid_o), .cmd_o(cmd_o), .len_o(len_o), .done_o(done_o),
    .pec_err_o(pec_err_o), .len_err_o(len_err_o), .pec_valid_o(pec_valid_o),
    .pec_init_o(pec_init_o), .pec_dat_o(pec_dat_o), .pec_crc_i(pec_crc_i), .state_o(state_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;
  int rdy_mode = 0;
  logic [7:0] exp_q[$];

  function automatic logic [7:0] crc8(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r;
    r = c ^ d;
    for (int i = 0; i < 8; i++) r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
    return r;
  endfunction

  function automatic bit pec_en();
`ifdef RECOVERY_RX_PEC_CHECK_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  // External CRC-8 engine: registered, one update per feed.
  logic [7:0] crc_q;
  always @(posedge clk) begin
    if (rst_i) crc_q <= 8'h00;
    else if (pec_valid_o) crc_q <= crc8(pec_init_o ? 8'h00 : crc_q, pec_dat_o);
  end
  assign pec_crc_i = crc_q;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=0x%0h req=0x%0h", name, act, exp);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  int hdr_cnt = 0, done_cnt = 0, init_cnt = 0;
  int hdr_cyc = -1, done_cyc = -1;
  logic [7:0]  hdr_cmd;
  logic [15:0] hdr_len;

  always @(negedge clk) begin
    if (!rst_i) begin
      if (hdr_valid_o) begin
        hdr_cnt++;
        hdr_cyc = cyc;
        hdr_cmd = cmd_o;
        hdr_len = len_o;
      end
      if (done_o) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (pec_init_o) init_cnt++;
      if (data_valid_o && data_ready_i) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL payload_extra act=0x%02h req=no_byte", data_o);
        end else begin
          check("payload", 32'(data_o), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame(input logic [6:0] a);
    addr_i = a;
    frame_start_i = 1'b1;
    tick();
    frame_start_i = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, output int acc_cyc);
    bit ok;
    ok = 1'b0;
    acc_cyc = -1;
    rx_valid_i = 1'b1;
    rx_data_i = b;
    for (int k = 0; k < 200 && !ok; k++) begin
      case (rdy_mode)
        0: data_ready_i = 1'b1;
        1: data_ready_i = ~data_ready_i;
        default: data_ready_i = 1'($urandom_range(0, 1));
      endcase
      @(negedge clk);
      if (rx_ready_o) begin
        ok = 1'b1;
        acc_cyc = cyc;
      end
      tick();
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL rx_accept_timeout act=not_accepted req=accepted byte=0x%02h", b);
    end
  endtask

  task automatic stop_frame(output int stop_cyc);
    frame_stop_i = 1'b1;
    stop_cyc = cyc;
    tick();
    frame_stop_i = 1'b0;
    tick();
    tick();
  endtask

  // ---------------- frame vectors ----------------
  typedef struct {
    logic [6:0]  addr;
    logic [7:0]  cmd;
    logic [15:0] len;
    bit          pec_auto;
    logic [7:0]  pec_byte;
    logic [7:0]  pec_xor;
    int          n_extra;
    int          n_send;
    int          rdy;
    bit          rnd_pay;
    bit          exp_len_err;
    bit          exp_pec_err;
    int          exp_npay;
    bit          exp_hdr;
  } vec_t;

  task automatic run_vec(input string tag, input vec_t v);
    logic [7:0] strm[$];
    logic [7:0] pay[$];
    logic [7:0] crc, b;
    bit over;
    int n, acc, lenh_cyc, stop_cyc, hdr0, done0, init0;
    logic [15:0] exp_len;
    over = (v.len > MaxLen);
    strm = {};
    pay = {};
    strm.push_back(v.cmd);
    strm.push_back(v.len[7:0]);
    strm.push_back(v.len[15:8]);
    crc = crc8(8'h00, {v.addr, 1'b0});
    crc = crc8(crc, v.cmd);
    crc = crc8(crc, v.len[7:0]);
    crc = crc8(crc, v.len[15:8]);
    if (!over) begin
      for (int i = 0; i < int'(v.len); i++) begin
        b = v.rnd_pay ? 8'($urandom_range(0, 255)) : 8'(i + 1);
        strm.push_back(b);
        pay.push_back(b);
        crc = crc8(crc, b);
      end
      strm.push_back((v.pec_auto ? crc : v.pec_byte) ^ v.pec_xor);
    end
    for (int i = 0; i < v.n_extra; i++) strm.push_back(8'($urandom_range(0, 255)));
    n = (v.n_send < 0) ? strm.size() : v.n_send;
    exp_q.delete();
    for (int i = 0; i < v.exp_npay; i++) exp_q.push_back(pay[i]);
    hdr0 = hdr_cnt;
    done0 = done_cnt;
    init0 = init_cnt;
    lenh_cyc = -1;
    rdy_mode = v.rdy;
    data_ready_i = 1'b1;

    start_frame(v.addr);
    for (int i = 0; i < n; i++) begin
      send_byte(strm[i], acc);
      if (i == 2) lenh_cyc = acc;
    end
    rx_valid_i = 1'b0;
    stop_frame(stop_cyc);

    exp_len = 16'h0000;
    if (n >= 2) exp_len[7:0] = v.len[7:0];
    if (n >= 3) exp_len[15:8] = v.len[15:8];
    check({tag, "_done_cnt"}, 32'(done_cnt - done0), 32'd1);
    check({tag, "_done_lat"}, 32'(done_cyc), 32'(stop_cyc + 1));
    check({tag, "_hdr_cnt"}, 32'(hdr_cnt - hdr0), 32'(v.exp_hdr));
    if (v.exp_hdr) begin
      check({tag, "_hdr_lat"}, 32'(hdr_cyc), 32'(lenh_cyc + 1));
      check({tag, "_hdr_cmd"}, 32'(hdr_cmd), 32'(v.cmd));
      check({tag, "_hdr_len"}, 32'(hdr_len), 32'(v.len));
    end
    check({tag, "_len_err"}, 32'(len_err_o), 32'(v.exp_len_err));
    check({tag, "_pec_err"}, 32'(pec_err_o), 32'(v.exp_pec_err & pec_en()));
    check({tag, "_cmd"}, 32'(cmd_o), (n >= 1) ? 32'(v.cmd) : 32'd0);
    check({tag, "_len"}, 32'(len_o), 32'(exp_len));
    check({tag, "_payload_left"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_pec_init_cnt"}, 32'(init_cnt - init0), 32'(pec_en()));
    check({tag, "_idle_ready"}, 32'(rx_ready_o), 32'd0);
    exp_q.delete();
  endtask

  // Frame-level model: derives expected status from how much of the frame was delivered.
  function automatic vec_t gen_rand();
    vec_t v;
    int r, full, n, npay, extras;
    bit over, pec_sent;
    v.addr = 7'($urandom_range(0, 127));
    v.cmd = 8'($urandom_range(0, 255));
    r = $urandom_range(0, 99);
    if (r < 75)      v.len = 16'($urandom_range(0, 6));
    else if (r < 85) v.len = 16'($urandom_range(250, 256));
    else             v.len = 16'($urandom_range(257, 600));
    v.pec_auto = 1'b1;
    v.pec_byte = 8'h00;
    v.pec_xor = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
    over = (v.len > MaxLen);
    v.n_extra = over ? $urandom_range(0, 4) : (($urandom_range(0, 4) == 0) ? $urandom_range(1, 2) : 0);
    full = over ? 3 + v.n_extra : 3 + int'(v.len) + 1 + v.n_extra;
    n = ($urandom_range(0, 2) == 0) ? $urandom_range(1, full) : full;
    v.n_send = n;
    v.rdy = $urandom_range(0, 2);
    v.rnd_pay = 1'b1;
    npay = over ? 0 : ((n - 3 < 0) ? 0 : ((n - 3 > int'(v.len)) ? int'(v.len) : n - 3));
    pec_sent = !over && (n >= 4 + int'(v.len));
    extras = pec_sent ? n - (4 + int'(v.len)) : 0;
    v.exp_npay = npay;
    v.exp_hdr = (n >= 3);
    v.exp_len_err = !pec_sent || (extras > 0);
    v.exp_pec_err = pec_sent && (v.pec_xor != 8'h00);
    return v;
  endfunction

  // ---------------- test sequence ----------------
  vec_t tbl[9];

  initial begin
    int acc, sc, d0, h0, i0;
    tbl[0] = '{7'h21, 8'h26, 16'h0000, 1'b0, 8'h89, 8'h00, 0, -1, 0, 1'b0, 1'b0, 1'b0, 0, 1'b1};
    tbl[1] = '{7'h21, 8'h26, 16'h0000, 1'b0, 8'h88, 8'h00, 0, -1, 0, 1'b0, 1'b0, 1'b1, 0, 1'b1};
    tbl[2] = '{7'h21, 8'h3a, 16'h0004, 1'b1, 8'h00, 8'h00, 0, -1, 1, 1'b0, 1'b0, 1'b0, 4, 1'b1};
    tbl[3] = '{7'h21, 8'h3b, 16'h0101, 1'b1, 8'h00, 8'h00, 5, -1, 0, 1'b0, 1'b1, 1'b0, 0, 1'b1};
    tbl[4] = '{7'h21, 8'h3c, 16'h0004, 1'b1, 8'h00, 8'h00, 0,  5, 0, 1'b0, 1'b1, 1'b0, 2, 1'b1};
    tbl[5] = '{7'h2a, 8'h3d, 16'h0002, 1'b1, 8'h00, 8'h00, 2, -1, 0, 1'b0, 1'b1, 1'b0, 2, 1'b1};
    tbl[6] = '{7'h11, 8'h40, 16'h0100, 1'b1, 8'h00, 8'h00, 0, -1, 2, 1'b0, 1'b0, 1'b0, 256, 1'b1};
    tbl[7] = '{7'h7f, 8'h41, 16'h0001, 1'b1, 8'h00, 8'h5a, 0, -1, 2, 1'b0, 1'b0, 1'b1, 1, 1'b1};
    tbl[8] = '{7'h21, 8'h42, 16'h0000, 1'b1, 8'h00, 8'h00, 0,  1, 0, 1'b0, 1'b1, 1'b0, 0, 1'b0};

    // Reset state
    tick(); tick(); tick();
    rst_i = 1'b0;
    tick();
    check("rst_rx_ready", 32'(rx_ready_o), 32'd0);
    check("rst_data_valid", 32'(data_valid_o), 32'd0);
    check("rst_data", 32'(data_o), 32'd0);
    check("rst_hdr_valid", 32'(hdr_valid_o), 32'd0);
    check("rst_cmd", 32'(cmd_o), 32'd0);
    check("rst_len", 32'(len_o), 32'd0);
    check("rst_done", 32'(done_o), 32'd0);
    check("rst_pec_err", 32'(pec_err_o), 32'd0);
    check("rst_len_err", 32'(len_err_o), 32'd0);
    check("rst_pec_valid", 32'(pec_valid_o), 32'd0);
    check("rst_pec_init", 32'(pec_init_o), 32'd0);
    check("rst_pec_dat", 32'(pec_dat_o), 32'd0);

    // Stop while idle is ignored
    d0 = done_cnt;
    frame_stop_i = 1'b1;
    tick();
    frame_stop_i = 1'b0;
    tick(); tick();
    check("idle_stop_no_done", 32'(done_cnt - d0), 32'd0);

    for (int i = 0; i < 9; i++) run_vec($sformatf("v%0d", i), tbl[i]);

    // Start mid-DATA aborts without done, next frame uses a fresh PEC seed
    d0 = done_cnt; h0 = hdr_cnt; i0 = init_cnt;
    rdy_mode = 0;
    exp_q.delete();
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h02);
    start_frame(7'h21);
    send_byte(8'h10, acc); send_byte(8'h04, acc); send_byte(8'h00, acc);
    send_byte(8'h01, acc); send_byte(8'h02, acc);
    rx_valid_i = 1'b0;
    start_frame(7'h21);
    check("abort_cmd_cleared", 32'(cmd_o), 32'd0);
    check("abort_len_cleared", 32'(len_o), 32'd0);
    check("abort_no_done", 32'(done_cnt - d0), 32'd0);
    send_byte(8'h26, acc); send_byte(8'h00, acc); send_byte(8'h00, acc); send_byte(8'h89, acc);
    rx_valid_i = 1'b0;
    stop_frame(sc);
    check("abort_done_cnt", 32'(done_cnt - d0), 32'd1);
    check("abort_hdr_cnt", 32'(hdr_cnt - h0), 32'd2);
    check("abort_cmd", 32'(cmd_o), 32'h26);
    check("abort_len_err", 32'(len_err_o), 32'd0);
    check("abort_pec_err", 32'(pec_err_o), 32'd0);
    check("abort_pec_init_cnt", 32'(init_cnt - i0), pec_en() ? 32'd2 : 32'd0);
    check("abort_payload_left", 32'(exp_q.size()), 32'd0);

    // Reset in DRAIN clears status and emits no done
    d0 = done_cnt;
    start_frame(7'h33);
    send_byte(8'h55, acc); send_byte(8'h01, acc); send_byte(8'h02, acc);
    rx_valid_i = 1'b0;
    check("drain_len_err_early", 32'(len_err_o), 32'd1);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    check("midrst_cmd", 32'(cmd_o), 32'd0);
    check("midrst_len", 32'(len_o), 32'd0);
    check("midrst_len_err", 32'(len_err_o), 32'd0);
    rx_valid_i = 1'b1;
    #1;
    check("midrst_rx_ready", 32'(rx_ready_o), 32'd0);
    rx_valid_i = 1'b0;
    tick(); tick();
    check("midrst_no_done", 32'(done_cnt - d0), 32'd0);

    // Randomized frames against the frame-level model
    for (int i = 0; i < 30; i++) run_vec($sformatf("r%0d", i), gen_rand());

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog act=running req=finished");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/recovery_rx_framer.md
# recovery_rx_framer

Byte-level framer for incoming I3C recovery write transfers, sitting between the I3C target byte receiver and the recovery command handler. It parses each frame (command code, 16-bit little-endian length, payload, PEC byte) and streams payload bytes downstream. It drives the external CRC-8 PEC calculator (`recovery_pec`, polynomial x^8+x^2+x+1, initial value 0x00) with the address byte and every covered frame byte, then compares the received PEC byte against the accumulated CRC.

## Interface
- `MaxLen`, default 256: maximum accepted payload length in bytes.
- `clk_i` input 1: clock.
- `rst_i` input 1: reset, synchronous, active-high.
- `frame_start_i` input 1: pulse marking a new write transfer, after the address is ACKed.
- `frame_stop_i` input 1: pulse on STOP or repeated START.
- `addr_i` input 7: own dynamic address, sampled on `frame_start_i`.
- `rx_valid_i` input 1, `rx_ready_o` output 1, `rx_data_i` input 8: upstream byte stream.
- `data_valid_o` output 1, `data_ready_i` input 1, `data_o` output 8: payload stream.
- `hdr_valid_o` output 1: one-cycle pulse when the header is complete.
- `cmd_o` output 8, `len_o` output 16: header fields.
- `done_o` output 1: one-cycle pulse at frame end.
- `pec_err_o` output 1, `len_err_o` output 1: frame status.
- `pec_valid_o` output 1, `pec_init_o` output 1, `pec_dat_o` output 8: drive the PEC calculator.
- `pec_crc_i` input 8: the PEC calculator's `crc_o`.

## Operation
- States: IDLE, ADDR, CMD, LEN_L, LEN_H, DATA, PEC, WAIT_STOP, DRAIN.
- A byte is accepted on `rx_valid_i && rx_ready_o`. `rx_ready_o` is 0 in IDLE and ADDR, and 0 whenever `frame_stop_i` is 1.
- `frame_start_i` in any state:
  - go to ADDR;
  - clear `pec_err_o`, `len_err_o`, `cmd_o`, `len_o`;
  - no `done_o` pulse.
- ADDR (exactly 1 cycle): `pec_valid_o`=1, `pec_init_o`=1, `pec_dat_o`={addr_i,1'b0}. Next state CMD.
- CMD / LEN_L / LEN_H:
  - accepted byte is captured into `cmd_o` / `len_o[7:0]` / `len_o[15:8]`;
  - the byte is fed to PEC with `pec_init_o`=0;
  - `rx_ready_o`=1.
- After LEN_H is accepted, `hdr_valid_o` pulses the next cycle. Next state:
  - `len`>`MaxLen`: DRAIN, with `len_err_o`=1;
  - `len`==0: PEC;
  - otherwise: DATA.
- DATA:
  - `data_o`=`rx_data_i`, `data_valid_o`=`rx_valid_i`, `rx_ready_o`=`data_ready_i` (combinational pass-through);
  - each accepted byte is fed to PEC and decrements a 16-bit remaining counter;
  - after the last byte, go to PEC.
- PEC:
  - accepted byte is not fed to PEC;
  - if the macro is enabled, set `pec_err_o` = (`rx_data_i` != `pec_crc_i`);
  - go to WAIT_STOP.
- WAIT_STOP: extra bytes are accepted and dropped, and set `len_err_o`.
- DRAIN: all bytes are accepted and dropped; no PEC feed; no data out.
- `frame_stop_i` in any state from CMD through DRAIN:
  - `done_o` pulses the next cycle and the FSM returns to IDLE;
  - if the state was CMD, LEN_L, LEN_H, DATA or PEC (frame ended short), `len_err_o` is set.
- `frame_stop_i` in IDLE or ADDR is ignored.
- `frame_stop_i` and `frame_start_i` in the same cycle: start wins.
- `pec_err_o`, `len_err_o`, `cmd_o`, `len_o` hold their values until the next `frame_start_i`.

## Timing
- Reset values:
  - state IDLE;
  - all outputs 0;
  - `pec_dat_o`=0x00.
- Throughput is 1 byte/cycle. The PEC register updates 1 cycle after each feed, so `pec_crc_i` is valid when the PEC byte arrives, even back-to-back.
- Latency:
  - `hdr_valid_o`: 1 cycle after the LEN_H handshake;
  - `done_o`: 1 cycle after `frame_stop_i`;
  - payload pass-through: 0 cycles.
- `pec_valid_o` is asserted only in the cycle of an accepted covered byte, or in ADDR.
- Reset mid-frame: return to IDLE next cycle; outputs cleared; no `done_o`.

## Configuration
- Macro: `RECOVERY_RX_PEC_CHECK_EN`.
- Defined: behaviour as described above.
- Undefined:
  - PEC byte is consumed and ignored;
  - `pec_err_o` tied to 0;
  - `pec_valid_o`, `pec_init_o` and `pec_dat_o` tied to 0;
  - all other behaviour unchanged.

## Test plan
- `addr_i`=0x21, frame 0x26,0x00,0x00,0x89, then stop.
  - Expect: `hdr_valid_o` with `cmd_o`=0x26, `len_o`=0; `done_o`; `pec_err_o`=0, `len_err_o`=0.
- Same frame with PEC byte 0x88.
  - Expect: `done_o`, `pec_err_o`=1 (with macro); `pec_err_o`=0 (without macro).
- `len`=4, payload 0x01..0x04 with `data_ready_i` toggling every cycle, correct PEC from the reference model.
  - Expect: 4 bytes out in order, stalls honoured, `pec_err_o`=0.
- `len`=0x0101 with `MaxLen`=256.
  - Expect: `len_err_o`=1, no payload out, bytes drained, `done_o` after stop.
- Stop after 2 of 4 payload bytes.
  - Expect: `done_o`, `len_err_o`=1, return to IDLE.
- `frame_start_i` mid-DATA, then a valid 0-length frame.
  - Expect: no `done_o` for the aborted frame; second frame completes cleanly with a fresh PEC init.
